// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-port ALU arbiter.
// Optional build macro: ALU_ARB_FIXED_PRIORITY_EN.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int CNT_W = 4;

  localparam logic [2:0] CODE_ARITH = 3'b000;
  localparam logic [2:0] CODE_EQ    = 3'b001;
  localparam logic [2:0] CODE_LT    = 3'b010;
  localparam logic [2:0] CODE_GT    = 3'b011;
  localparam logic [2:0] CODE_CLX   = 3'b100;
  localparam logic [2:0] CODE_ADDI  = 3'b101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  // Counter preload; the settle window is clamped to 1..15 cycles.
  function automatic logic [CNT_W-1:0] settle_load(input int cycles);
    logic [CNT_W-1:0] v;
    if (cycles < 1) begin
      v = '0;
    end else if (cycles > 15) begin
      v = CNT_W'(14);
    end else begin
      v = CNT_W'(cycles - 1);
    end
    return v;
  endfunction

endpackage

// File: rtl/alu_arb_grant.sv
// Combinational two-way grant: round-robin by default,
// fixed port-0 priority with ALU_ARB_FIXED_PRIORITY_EN.
module alu_arb_grant
  import alu_arb_pkg::*;
(
  input  logic valid_0_i,
  input  logic valid_1_i,
  input  logic last_grant_i,
  output logic grant_0_o,
  output logic grant_1_o
);

`ifdef ALU_ARB_FIXED_PRIORITY_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

  always_comb begin
    grant_0_o = 1'b0;
    grant_1_o = 1'b0;
    unique case (1'b1)
      (valid_0_i && valid_1_i): begin
`ifdef ALU_ARB_FIXED_PRIORITY_EN
        grant_0_o = 1'b1;
`else
        // Tie goes to whichever port was not served last.
        grant_0_o = last_grant_i;
        grant_1_o = !last_grant_i;
`endif
      end
      (valid_0_i && !valid_1_i): grant_0_o = 1'b1;
      (!valid_0_i && valid_1_i): grant_1_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters.
// Build macro ALU_ARB_FIXED_PRIORITY_EN selects fixed port-0 priority.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int OP_W          = 6,
  parameter int CODE_W        = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_0,
  output logic              req_ready_0,
  input  logic [OP_W-1:0]   req_op_0,
  input  logic [CODE_W-1:0] req_code_0,
  input  logic [WIDTH-1:0]  req_a_0,
  input  logic [WIDTH-1:0]  req_b_0,
  input  logic              req_valid_1,
  output logic              req_ready_1,
  input  logic [OP_W-1:0]   req_op_1,
  input  logic [CODE_W-1:0] req_code_1,
  input  logic [WIDTH-1:0]  req_a_1,
  input  logic [WIDTH-1:0]  req_b_1,
  output logic              rsp_valid_0,
  input  logic              rsp_ready_0,
  output logic              rsp_valid_1,
  input  logic              rsp_ready_1,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              rsp_zero,
  output logic [OP_W-1:0]   alu_operation,
  output logic [CODE_W-1:0] alu_code,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero
);

  localparam logic [CNT_W-1:0] CNT_LOAD =
    settle_load(SETTLE_CYCLES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              own_q, own_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              zero_q, zero_d;
  logic              rv0_q, rv0_d;
  logic              rv1_q, rv1_d;

  logic gnt_0, gnt_1;
  logic rdy_0, rdy_1;
  logic hs_0, hs_1;
  logic rsp_take;

  alu_arb_grant u_grant (
    .valid_0_i    (req_valid_0),
    .valid_1_i    (req_valid_1),
    .last_grant_i (last_q),
    .grant_0_o    (gnt_0),
    .grant_1_o    (gnt_1)
  );

  // Ready is masked during reset so every output reads 0 there.
  assign rdy_0 = (state_q == IDLE) && gnt_0 && !reset;
  assign rdy_1 = (state_q == IDLE) && gnt_1 && !reset;
  assign hs_0  = rdy_0 && req_valid_0;
  assign hs_1  = rdy_1 && req_valid_1;

  assign rsp_take = own_q ? rsp_ready_1 : rsp_ready_0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    own_d   = own_q;
    op_d    = op_q;
    code_d  = code_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    zero_d  = zero_q;
    rv0_d   = rv0_q;
    rv1_d   = rv1_q;
    unique case (state_q)
      IDLE: begin
        if (hs_1) begin
          own_d   = 1'b1;
          op_d    = req_op_1;
          code_d  = req_code_1;
          a_d     = req_a_1;
          b_d     = req_b_1;
          cnt_d   = CNT_LOAD;
          state_d = EXEC;
        end else if (hs_0) begin
          own_d   = 1'b0;
          op_d    = req_op_0;
          code_d  = req_code_0;
          a_d     = req_a_0;
          b_d     = req_b_0;
          cnt_d   = CNT_LOAD;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          data_d  = alu_result;
          zero_d  = alu_zero;
          rv0_d   = !own_q;
          rv1_d   = own_q;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_take) begin
          rv0_d   = 1'b0;
          rv1_d   = 1'b0;
          last_d  = own_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      own_q   <= 1'b0;
      op_q    <= '0;
      code_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      zero_q  <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      own_q   <= own_d;
      op_q    <= op_d;
      code_q  <= code_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
    end
  end

  assign req_ready_0   = rdy_0;
  assign req_ready_1   = rdy_1;
  assign rsp_valid_0   = rv0_q;
  assign rsp_valid_1   = rv1_q;
  assign rsp_data      = data_q;
  assign rsp_zero      = zero_q;
  assign alu_operation = op_q;
  assign alu_code      = code_q;
  assign alu_a         = a_q;
  assign alu_b         = b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU,
// per-port expected-result queues and a grant-order log.
`timescale 1ns/1ps
module tb_alu_arbiter;

  localparam logic [2:0] C_ARITH = 3'b000;
  localparam logic [2:0] C_CLX   = 3'b100;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;

  typedef struct {
    logic [31:0] d;
    logic        z;
  } exp_t;

  typedef struct {
    int          port;
    logic [5:0]  op;
    logic [2:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        z;
  } vec_t;

  int checks = 0;
  int failures = 0;

  exp_t q0[$];
  exp_t q1[$];
  int   glog[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v0 = 0, v1 = 0, rr0 = 1, rr1 = 1;
  logic        rdy0, rdy1, rv0, rv1, rz, az;
  logic [5:0]  op0 = 0, op1 = 0, aop;
  logic [2:0]  cd0 = 0, cd1 = 0, acd;
  logic [31:0] a0 = 0, a1 = 0, b0 = 0, b1 = 0;
  logic [31:0] rd, aa, ab, ar;

  logic        s_v = 0, s_rr = 1, s_rdy, s_rdy1, s_rv, s_rv1, s_rz, s_az;
  logic [5:0]  s_op = 0, s_aop;
  logic [2:0]  s_cd = 0, s_acd;
  logic [31:0] s_a = 0, s_rd, s_aa, s_ab, s_ar;

  // Reference ALU: a few arithmetic/logic functions plus count-leading-zeros.
  function automatic logic [32:0] alu_f(input logic [5:0] op,
    input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        z;
    r = '0;
    z = 1'b0;
    if (c == C_ARITH) begin
      case (op)
        F_ADD: begin r = a + b; z = (r == 0); end
        F_SUB: begin r = a - b; z = (r == 0); end
        F_AND: r = a & b;
        F_OR:  r = a | b;
        default: r = '0;
      endcase
    end else if (c == C_CLX && op == F_ADD) begin
      r = 32;
      for (int i = 0; i < 32; i++) if (a[i]) r = 31 - i;
    end
    return {z, r};
  endfunction

  assign {az, ar}     = alu_f(aop, acd, aa, ab);
  assign {s_az, s_ar} = alu_f(s_aop, s_acd, s_aa, 32'h0);

  alu_arbiter u_dut (
    .clk(clk), .reset(rst),
    .req_valid_0(v0), .req_ready_0(rdy0), .req_op_0(op0),
    .req_code_0(cd0), .req_a_0(a0), .req_b_0(b0),
    .req_valid_1(v1), .req_ready_1(rdy1), .req_op_1(op1),
    .req_code_1(cd1), .req_a_1(a1), .req_b_1(b1),
    .rsp_valid_0(rv0), .rsp_ready_0(rr0),
    .rsp_valid_1(rv1), .rsp_ready_1(rr1),
    .rsp_data(rd), .rsp_zero(rz),
    .alu_operation(aop), .alu_code(acd), .alu_a(aa), .alu_b(ab),
    .alu_result(ar), .alu_zero(az)
  );

  alu_arbiter #(.SETTLE_CYCLES(4)) u_dut4 (
    .clk(clk), .reset(rst),
    .req_valid_0(s_v), .req_ready_0(s_rdy), .req_op_0(s_op),
    .req_code_0(s_cd), .req_a_0(s_a), .req_b_0(32'h0),
    .req_valid_1(1'b0), .req_ready_1(s_rdy1), .req_op_1(6'h0),
    .req_code_1(3'h0), .req_a_1(32'h0), .req_b_1(32'h0),
    .rsp_valid_0(s_rv), .rsp_ready_0(s_rr),
    .rsp_valid_1(s_rv1), .rsp_ready_1(1'b1),
    .rsp_data(s_rd), .rsp_zero(s_rz),
    .alu_operation(s_aop), .alu_code(s_acd), .alu_a(s_aa), .alu_b(s_ab),
    .alu_result(s_ar), .alu_zero(s_az)
  );

  task automatic chk(input string nm, input logic [31:0] act,
    input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic pop_chk(input int p);
    exp_t e;
    if (p == 0 && q0.size() == 0 || p == 1 && q1.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_rsp port %0d: got %h expected none", p, rd);
    end else begin
      e = (p == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("rsp_data_p%0d", p), rd, e.d);
      chk($sformatf("rsp_zero_p%0d", p), {31'b0, rz}, {31'b0, e.z});
    end
  endtask

  // Handshakes are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rv0 && rr0) pop_chk(0);
      if (rv1 && rr1) pop_chk(1);
      if (v0 && rdy0) glog.push_back(0);
      if (v1 && rdy1) glog.push_back(1);
      chk("ready_onehot", {31'b0, rdy0 & rdy1}, 32'h0);
    end
  end

  task automatic send(input int p, input logic [5:0] op,
    input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] d, input logic z);
    exp_t e;
    bit   ok;
    e.d = d;
    e.z = z;
    if (p == 0) q0.push_back(e); else q1.push_back(e);
    @(posedge clk) #1;
    if (p == 0) begin
      v0 = 1; op0 = op; cd0 = c; a0 = a; b0 = b;
    end else begin
      v1 = 1; op1 = op; cd1 = c; a1 = a; b1 = b;
    end
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = (p == 0) ? rdy0 : rdy1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout port %0d: got no ready expected ready", p);
    end
    @(posedge clk) #1;
    if (p == 0) v0 = 0; else v1 = 0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      done = (q0.size() == 0) && (q1.size() == 0);
    end
    chk("drain", {31'b0, done}, 32'h1);
  endtask

  vec_t vt[6];
  int   exp_g[4];

  initial begin
    vt[0] = '{0, F_ADD, C_ARITH, 32'd100, 32'd23, 32'd123, 1'b0};
    vt[1] = '{1, F_OR,  C_ARITH, 32'h0F, 32'hF0, 32'hFF, 1'b0};
    vt[2] = '{0, F_SUB, C_ARITH, 32'd10, 32'd3, 32'd7, 1'b0};
    vt[3] = '{1, F_ADD, C_ARITH, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1};
    vt[4] = '{0, F_AND, C_ARITH, 32'h1234_5678, 32'h0000_FFFF,
              32'h0000_5678, 1'b0};
    vt[5] = '{1, F_SUB, C_ARITH, 32'd2, 32'd5, 32'hFFFF_FFFD, 1'b0};

    // Reset values
    #12;
    chk("rst_ready0", {31'b0, rdy0}, 32'h0);
    chk("rst_rsp_valid", {30'b0, rv1, rv0}, 32'h0);
    chk("rst_rsp_data", rd, 32'h0);
    chk("rst_rsp_zero", {31'b0, rz}, 32'h0);
    chk("rst_alu_a", aa, 32'h0);
    chk("rst_alu_op", {26'b0, aop}, 32'h0);
    @(posedge clk) #1 rst = 0;

    // Single request latency: ready, then rsp_valid two cycles on
    send(0, F_ADD, C_ARITH, 32'd5, 32'd7, 32'd12, 1'b0);
    chk("t1_alu_a", aa, 32'd5);
    @(negedge clk);
    chk("t1_rv_early", {31'b0, rv0}, 32'h0);
    @(negedge clk);
    chk("t1_rv0", {31'b0, rv0}, 32'h1);
    chk("t1_data", rd, 32'd12);
    chk("t1_zero", {31'b0, rz}, 32'h0);
    drain();

    for (int i = 0; i < 6; i++) begin
      send(vt[i].port, vt[i].op, vt[i].code, vt[i].a, vt[i].b,
           vt[i].d, vt[i].z);
      drain();
    end

    // Contention
    glog.delete();
    fork
      begin
        send(0, F_AND, C_ARITH, 32'hF0F0_0000, 32'hFF00_FF00,
             32'hF000_0000, 1'b0);
        send(0, F_AND, C_ARITH, 32'hF0F0_0000, 32'hFF00_FF00,
             32'hF000_0000, 1'b0);
      end
      begin
        send(1, F_SUB, C_ARITH, 32'd3, 32'd3, 32'd0, 1'b1);
        send(1, F_SUB, C_ARITH, 32'd3, 32'd3, 32'd0, 1'b1);
      end
    join
    drain();
`ifdef ALU_ARB_FIXED_PRIORITY_EN
    exp_g = '{0, 0, 1, 1};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    chk("t2_grant_count", glog.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t2_grant_%0d", i),
          (i < glog.size()) ? glog[i] : 9, exp_g[i]);

    // Response backpressure on port 1
    rr1 = 0;
    send(1, F_SUB, C_ARITH, 32'd9, 32'd4, 32'd5, 1'b0);
    fork
      send(0, F_OR, C_ARITH, 32'h3, 32'hC, 32'hF, 1'b0);
    join_none
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        seen = rv1;
      end
      chk("t3_rv1_seen", {31'b0, seen}, 32'h1);
    end
    for (int i = 0; i < 5; i++) begin
      chk("t3_rv1_hold", {31'b0, rv1}, 32'h1);
      chk("t3_data_hold", rd, 32'd5);
      chk("t3_ready0_low", {31'b0, rdy0}, 32'h0);
      @(negedge clk);
    end
    @(posedge clk) #1 rr1 = 1;
    @(negedge clk);
    @(negedge clk);
    chk("t3_ready0_after", {31'b0, rdy0}, 32'h1);
    drain();

    // SETTLE_CYCLES=4 instance, count leading zeros
    @(posedge clk) #1;
    s_v = 1; s_op = F_ADD; s_cd = C_CLX; s_a = 32'h0000_FFFF;
    begin
      bit ok;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
        @(negedge clk);
        ok = s_rdy;
      end
      chk("t4_accept", {31'b0, ok}, 32'h1);
    end
    @(posedge clk) #1 s_v = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("t4_rv_low", {31'b0, s_rv}, 32'h0);
      chk("t4_alu_a", s_aa, 32'h0000_FFFF);
      chk("t4_alu_code", {29'b0, s_acd}, {29'b0, C_CLX});
    end
    @(negedge clk);
    chk("t4_rv", {31'b0, s_rv}, 32'h1);
    chk("t4_data", s_rd, 32'd16);

    // Reset while executing
    send(0, F_ADD, C_ARITH, 32'd1, 32'd2, 32'd3, 1'b0);
    #2 rst = 1;
    #1;
    chk("t5_rv0", {31'b0, rv0}, 32'h0);
    chk("t5_alu_a", aa, 32'h0);
    chk("t5_alu_op", {26'b0, aop}, 32'h0);
    chk("t5_data", rd, 32'h0);
    q0.delete();
    @(posedge clk) #1 rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_no_rsp", {30'b0, rv1, rv0}, 32'h0);
    end
    glog.delete();
    fork
      send(0, F_ADD, C_ARITH, 32'd2, 32'd2, 32'd4, 1'b0);
      send(1, F_ADD, C_ARITH, 32'd3, 32'd3, 32'd6, 1'b0);
    join
    drain();
    chk("t5_first_grant", (glog.size() > 0) ? glog[0] : 9, 32'd0);

    chk("q_empty", q0.size() + q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single combinational ALU between two requesters using valid/ready handshakes. Port 0 is the main pipeline and port 1 is a secondary client, such as a debug or multi-cycle helper. The block arbitrates, latches the winner's operands, and holds them stable at the ALU for a programmable settle time. It then registers the result and returns it to the winning port with its own valid/ready response handshake.

Parameters:
WIDTH, 32, operand/result width
OP_W, 6, function-code (operation) width
CODE_W, 3, aluCode width
SETTLE_CYCLES, 1, cycles operands are held at the ALU before the result is captured (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid_0  input  1  port 0 request valid
req_ready_0  output  1  port 0 request accepted this cycle
req_op_0  input  OP_W  port 0 function code
req_code_0  input  CODE_W  port 0 aluCode
req_a_0  input  WIDTH  port 0 operand a
req_b_0  input  WIDTH  port 0 operand b
req_valid_1 / req_ready_1 / req_op_1 / req_code_1 / req_a_1 / req_b_1  as port 0, for port 1
rsp_valid_0  output  1  port 0 result valid
rsp_ready_0  input  1  port 0 result consumed
rsp_valid_1  output  1  port 1 result valid
rsp_ready_1  input  1  port 1 result consumed
rsp_data  output  WIDTH  registered result (shared by both ports, qualified by rsp_valid_N)
rsp_zero  output  1  registered zeroFlag
alu_operation  output  OP_W  to ALU operation
alu_code  output  CODE_W  to ALU aluCode
alu_a  output  WIDTH  to ALU a
alu_b  output  WIDTH  to ALU b
alu_result  input  WIDTH  from ALU Result
alu_zero  input  1  from ALU zeroFlag

Behaviour:
- Clock and reset: one clock, clk. The reset port is named reset and is asynchronous, active-high.
- Reset values:
  - State is IDLE.
  - All req_ready, rsp_valid, rsp_data, rsp_zero, alu_* outputs are 0.
  - Settle counter is 0.
  - Round-robin pointer last_grant is 1, so port 0 wins the first tie.
- State machine, IDLE:
  - The grant is computed combinationally from req_valid_0/1 and last_grant.
  - req_ready_N = (state==IDLE) && grant_N. At most one ready is asserted per cycle.
  - On a handshake, the winner's op/code/a/b are latched into the alu_* registers. The counter loads SETTLE_CYCLES-1 and the state goes to EXEC.
  - With no valid request, the state stays IDLE and the alu_* registers hold their last values.
- State machine, EXEC:
  - alu_* stay stable.
  - While the counter is nonzero, it decrements.
  - When the counter is 0, alu_result goes to rsp_data and alu_zero goes to rsp_zero. The state goes to RESP and rsp_valid_N is set for the granted port.
- State machine, RESP:
  - rsp_valid_N is held, and rsp_data/rsp_zero are stable, until rsp_ready_N is sampled high.
  - Then rsp_valid_N clears, last_grant takes N, and the state returns to IDLE.
  - No new request is accepted in RESP.
- Latency: accept to rsp_valid is SETTLE_CYCLES+1 cycles. Minimum spacing between accepts is SETTLE_CYCLES+2 cycles.
- Arbitration:
  - A single valid request always wins.
  - When both are valid, the port not equal to last_grant wins, giving strict alternation under continuous contention.
- Requester rules: req_valid_N must stay high with stable payload until req_ready_N. A request withdrawn before acceptance is simply never granted; this is not an error.
- ALU semantics are passed through unchanged:
  - For MOVN/MOVZ with a false condition, the ALU holds its previous Result, and the arbiter captures whatever alu_result shows.
  - rsp_zero is meaningful only for signed add/sub.
- Mid-operation reset: an asynchronous assert forces IDLE and clears all outputs. The in-flight operation is discarded and no response is issued.
- rsp_ready_N for the non-granted port, or outside RESP, is ignored.

Optional Feature:
ALU_ARB_FIXED_PRIORITY_EN
- Defined: port 0 always wins a tie, and last_grant is not used for selection. Port 1 is served only when req_valid_0 is low in IDLE.
- Undefined: round-robin as above.

Decomposition:
- Package alu_arb_pkg holds:
  - state enum IDLE/EXEC/RESP
  - localparams for the aluCode values (ARITH=000, EQ=001, LT=010, GT=011, CLX=100, ADDI=101)
  - commonly used function codes (ADD=100000, SUB=100010, AND=100100, OR=100101)
- One natural sub-module, alu_arb_grant: the combinational 2-way grant (round-robin/fixed) taking valid_0, valid_1 and last_grant, producing grant_0 and grant_1.

Test Plan:
1. Reset then single request: port 0, code 000, op 100000, a=5, b=7, SETTLE_CYCLES=1. Required: req_ready_0 the same cycle, rsp_valid_0 2 cycles later, rsp_data=12, rsp_zero=0.
2. Contention: both ports valid every cycle, port 0 AND (F0F0_0000 & FF00_FF00), port 1 SUB (3-3). Required: grants alternate 0,1,0,1. Port 0 data=F000_0000; port 1 data=0 with rsp_zero=1.
3. Response backpressure: rsp_ready_1 low for 5 cycles after rsp_valid_1. Required: rsp_valid_1 and rsp_data held stable, req_ready_0 stays 0 throughout, port 0 accepted the cycle after the rsp_ready_1 handshake.
4. SETTLE_CYCLES=4, op CLZ (code 100, op 100000), a=0000_FFFF. Required: alu_* stable for 4 cycles, rsp_valid 5 cycles after accept, rsp_data=16.
5. Reset asserted in EXEC. Required: outputs zero immediately (asynchronous), no rsp_valid, next request accepted normally with port 0 winning a tie.
6. With ALU_ARB_FIXED_PRIORITY_EN, both ports valid continuously. Required: port 0 granted every time and port 1 never granted until req_valid_0 drops.
